// File: rtl/tape_pkg.sv
// Shared state encoding and default timing constants for the tape receive path.
// Timing constants are in T-states unless noted otherwise.
package tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PILOT,
    ST_SYNC2,
    ST_DATA
  } tape_state_t;

  localparam int TAPE_CLK_DIV     = 4;
  localparam int TAPE_GLITCH      = 8;
  localparam int TAPE_PILOT_LO    = 1800;
  localparam int TAPE_PILOT_HI    = 2600;
  localparam int TAPE_PILOT_COUNT = 256;
  localparam int TAPE_SYNC_MAX    = 1000;
  localparam int TAPE_BIT_THRESH  = 2560;
  localparam int TAPE_BIT_MAX     = 4500;
  localparam int TAPE_TIMEOUT     = 14000;

  localparam int WIDTH_BITS = 14;
  localparam logic [WIDTH_BITS-1:0] WIDTH_SAT = '1;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tape_pulse_meter.sv
// Synchronises and de-glitches tape_in, then measures the width of each
// half-pulse in T-states and flags a single timeout per silent stretch.
module tape_pulse_meter import tape_pkg::*; #(
  parameter int CLK_DIV = TAPE_CLK_DIV,
  parameter int GLITCH  = TAPE_GLITCH,
  parameter int TIMEOUT = TAPE_TIMEOUT
) (
  input  logic                  clk14,
  input  logic                  rst_n,
  input  logic                  tape_in,
  output logic                  pulse,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  tmo
);

  localparam int SYNC_STAGES = 2;
  localparam int PW = bits_for(CLK_DIV);
  localparam int GW = bits_for(GLITCH);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH - 1);
  localparam logic [WIDTH_BITS-1:0] TMO_W = WIDTH_BITS'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level_reg;
  logic [GW-1:0]          glitch_cnt_reg;
  logic [PW-1:0]          presc_reg;
  logic [WIDTH_BITS-1:0]  count_reg;
  logic [WIDTH_BITS-1:0]  width_reg;
  logic                   armed_reg;
  logic                   pulse_reg;
  logic                   tmo_reg;

  logic synced;
  logic edge_det;
  logic tick;

  assign synced   = sync_reg[SYNC_STAGES-1];
  // A new level is accepted only once it has been stable for GLITCH cycles.
  assign edge_det = (synced != level_reg) && (glitch_cnt_reg == GLITCH_LAST);
  assign tick     = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      sync_reg       <= '0;
      level_reg      <= 1'b0;
      glitch_cnt_reg <= '0;
      presc_reg      <= '0;
      count_reg      <= '0;
      width_reg      <= '0;
      armed_reg      <= 1'b1;
      pulse_reg      <= 1'b0;
      tmo_reg        <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], tape_in};
      presc_reg <= tick ? '0 : presc_reg + PW'(1);

      if (synced == level_reg) begin
        glitch_cnt_reg <= '0;
      end else if (edge_det) begin
        level_reg      <= synced;
        glitch_cnt_reg <= '0;
      end else begin
        glitch_cnt_reg <= glitch_cnt_reg + GW'(1);
      end

      pulse_reg <= edge_det;
      tmo_reg   <= 1'b0;
      if (edge_det) begin
        width_reg <= count_reg;
        count_reg <= '0;
        armed_reg <= 1'b1;
      end else begin
        if (tick && (count_reg != WIDTH_SAT)) begin
          count_reg <= count_reg + WIDTH_BITS'(1);
        end
        // The counter sits at TIMEOUT for several cycles; fire only once.
        if (armed_reg && (count_reg == TMO_W)) begin
          tmo_reg   <= 1'b1;
          armed_reg <= 1'b0;
        end
      end
    end
  end

  assign pulse = pulse_reg;
  assign width = width_reg;
  assign tmo   = tmo_reg;

endmodule

// File: rtl/tape_decoder.sv
// Tape receive decoder: recognises pilot/sync framing, turns bit pairs into
// MSB-first bytes and hands them out through a valid/ready register.
module tape_decoder import tape_pkg::*; #(
  parameter int CLK_DIV     = TAPE_CLK_DIV,
  parameter int GLITCH      = TAPE_GLITCH,
  parameter int PILOT_LO    = TAPE_PILOT_LO,
  parameter int PILOT_HI    = TAPE_PILOT_HI,
  parameter int PILOT_COUNT = TAPE_PILOT_COUNT,
  parameter int SYNC_MAX    = TAPE_SYNC_MAX,
  parameter int BIT_THRESH  = TAPE_BIT_THRESH,
  parameter int BIT_MAX     = TAPE_BIT_MAX,
  parameter int TIMEOUT     = TAPE_TIMEOUT
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tape_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_first,
  output logic       block_active,
  output logic       block_end,
  output logic       block_ok,
  output logic       err,
  output logic       overrun
);

  localparam int PCW      = bits_for(PILOT_COUNT + 1);
  localparam int SUM_BITS = WIDTH_BITS + 1;
  localparam logic [WIDTH_BITS-1:0] PILOT_LO_W = WIDTH_BITS'(PILOT_LO);
  localparam logic [WIDTH_BITS-1:0] PILOT_HI_W = WIDTH_BITS'(PILOT_HI);
  localparam logic [WIDTH_BITS-1:0] SYNC_MAX_W = WIDTH_BITS'(SYNC_MAX);
  localparam logic [SUM_BITS-1:0]   THRESH_S   = SUM_BITS'(BIT_THRESH);
  localparam logic [SUM_BITS-1:0]   MAX_S      = SUM_BITS'(BIT_MAX);
  localparam logic [PCW-1:0]        PILOT_C    = PCW'(PILOT_COUNT);

  logic                  pulse;
  logic                  tmo;
  logic [WIDTH_BITS-1:0] width;

  tape_pulse_meter #(
    .CLK_DIV (CLK_DIV),
    .GLITCH  (GLITCH),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk14   (clk14),
    .rst_n   (rst_n),
    .tape_in (tape_in),
    .pulse   (pulse),
    .width   (width),
    .tmo     (tmo)
  );

  tape_state_t           state_reg, state_next;
  logic [PCW-1:0]        pilot_cnt_reg, pilot_cnt_next;
  logic                  phase_reg, phase_next;
  logic [WIDTH_BITS-1:0] first_half_reg, first_half_next;
  logic [2:0]            bit_cnt_reg, bit_cnt_next;
  logic [7:0]            shift_reg, shift_next;
  logic [7:0]            csum_reg, csum_next;
  logic                  first_pend_reg, first_pend_next;
  logic [7:0]            data_reg, data_next;
  logic                  first_reg, first_next;
  logic                  valid_reg, valid_next;
  logic                  end_reg, end_next;
  logic                  ok_reg, ok_next;
  logic                  err_reg, err_next;
  logic                  overrun_reg, overrun_next;

  logic                in_pilot;
  logic                is_sync;
  logic                bit_val;
  logic                byte_done;
  logic [SUM_BITS-1:0] pair_sum;
  logic [7:0]          byte_new;

  assign in_pilot = (width >= PILOT_LO_W) && (width <= PILOT_HI_W);
  assign is_sync  = (width < SYNC_MAX_W);
  assign pair_sum = {1'b0, first_half_reg} + {1'b0, width};
  assign bit_val  = (pair_sum > THRESH_S);
  assign byte_new = {shift_reg[6:0], bit_val};

  always_comb begin
    state_next      = state_reg;
    pilot_cnt_next  = pilot_cnt_reg;
    phase_next      = phase_reg;
    first_half_next = first_half_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    csum_next       = csum_reg;
    first_pend_next = first_pend_reg;
    data_next       = data_reg;
    first_next      = first_reg;
    valid_next      = valid_reg;
    overrun_next    = overrun_reg;
    end_next        = 1'b0;
    ok_next         = 1'b0;
    err_next        = 1'b0;
    byte_done       = 1'b0;

    if (valid_reg && byte_ready) begin
      valid_next = 1'b0;
    end

    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pulse && in_pilot) begin
            state_next     = ST_PILOT;
            pilot_cnt_next = PCW'(1);
          end
        end
        ST_PILOT: begin
          if (tmo) begin
            state_next = ST_IDLE;
          end else if (pulse) begin
            if (in_pilot) begin
              if (pilot_cnt_reg != PILOT_C) pilot_cnt_next = pilot_cnt_reg + PCW'(1);
            end else if (is_sync && (pilot_cnt_reg >= PILOT_C)) begin
              state_next = ST_SYNC2;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_SYNC2: begin
          if (tmo) begin
            state_next = ST_IDLE;
          end else if (pulse) begin
            if (is_sync) begin
              state_next      = ST_DATA;
              bit_cnt_next    = '0;
              phase_next      = 1'b0;
              csum_next       = '0;
              overrun_next    = 1'b0;
              first_pend_next = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tmo) begin
            end_next   = 1'b1;
            ok_next    = (csum_reg == 8'h00) && !overrun_reg && (bit_cnt_reg == 3'd0);
            state_next = ST_IDLE;
          end else if (pulse) begin
            if (!phase_reg) begin
              first_half_next = width;
              phase_next      = 1'b1;
            end else begin
              phase_next = 1'b0;
              if (pair_sum > MAX_S) begin
                err_next   = 1'b1;
                end_next   = 1'b1;
                state_next = ST_IDLE;
              end else begin
                shift_next = byte_new;
                if (bit_cnt_reg == 3'd7) begin
                  byte_done       = 1'b1;
                  bit_cnt_next    = '0;
                  csum_next       = csum_reg ^ byte_new;
                  first_pend_next = 1'b0;
                end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                end
              end
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // A byte finishing while the previous one is still held is lost.
    if (byte_done) begin
      if (valid_reg && !byte_ready) begin
        overrun_next = 1'b1;
      end else begin
        data_next  = byte_new;
        first_next = first_pend_reg;
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk14) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pilot_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
      first_half_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      csum_reg       <= '0;
      first_pend_reg <= 1'b0;
      data_reg       <= '0;
      first_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      end_reg        <= 1'b0;
      ok_reg         <= 1'b0;
      err_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pilot_cnt_reg  <= pilot_cnt_next;
      phase_reg      <= phase_next;
      first_half_reg <= first_half_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      csum_reg       <= csum_next;
      first_pend_reg <= first_pend_next;
      data_reg       <= data_next;
      first_reg      <= first_next;
      valid_reg      <= valid_next;
      end_reg        <= end_next;
      ok_reg         <= ok_next;
      err_reg        <= err_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign byte_data    = data_reg;
  assign byte_first   = first_reg;
  assign byte_valid   = valid_reg;
  assign block_active = (state_reg == ST_DATA);
  assign block_end    = end_reg;
  assign block_ok     = ok_reg;
  assign err          = err_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_tape_decoder.sv
// Scoreboard bench for tape_decoder: drives framed tape blocks and checks
// decoded bytes and block results against queued expectations.
module tb_tape_decoder;

  // Tape timings scaled down from the ROM standard so each block stays short.
  localparam int CDIV  = 2;
  localparam int GLT   = 8;
  localparam int P_LO  = 45;
  localparam int P_HI  = 65;
  localparam int P_CNT = 16;
  localparam int S_MAX = 25;
  localparam int B_TH  = 64;
  localparam int B_MAX = 112;
  localparam int TMO   = 350;

  localparam int PIL  = 54;
  localparam int SY1  = 17;
  localparam int SY2  = 18;
  localparam int ZERO = 21;
  localparam int ONE  = 43;

  logic       clk14 = 1'b0;
  logic       rst_n;
  logic       en;
  logic       tape_in;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_first;
  logic       block_active;
  logic       block_end;
  logic       block_ok;
  logic       err;
  logic       overrun;

  tape_decoder #(
    .CLK_DIV (CDIV), .GLITCH (GLT), .PILOT_LO (P_LO), .PILOT_HI (P_HI),
    .PILOT_COUNT (P_CNT), .SYNC_MAX (S_MAX), .BIT_THRESH (B_TH),
    .BIT_MAX (B_MAX), .TIMEOUT (TMO)
  ) dut (
    .clk14        (clk14),
    .rst_n        (rst_n),
    .en           (en),
    .tape_in      (tape_in),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_first   (byte_first),
    .block_active (block_active),
    .block_end    (block_end),
    .block_ok     (block_ok),
    .err          (err),
    .overrun      (overrun)
  );

  always #5 clk14 = ~clk14;

  int n_checks = 0;
  int n_fail   = 0;
  int blk_cnt  = 0;
  int err_cnt  = 0;

  logic [8:0] exp_byte_q [$];
  logic       exp_ok_q [$];
  logic [7:0] tx_bytes [4];
  logic       tape_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int t);
    repeat (t * CDIV) @(posedge clk14);
    #1;
  endtask

  task automatic half(input int t);
    tape_lvl = ~tape_lvl;
    tape_in  = tape_lvl;
    idle(t);
  endtask

  task automatic half_glitch(input int t);
    tape_lvl = ~tape_lvl;
    tape_in  = tape_lvl;
    idle(20);
    tape_in = ~tape_lvl;
    repeat (3) @(posedge clk14);
    #1;
    tape_in = tape_lvl;
    repeat (t * CDIV - 20 * CDIV - 3) @(posedge clk14);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) begin
        half(ONE);
        half(ONE);
      end else begin
        half(ZERO);
        half(ZERO);
      end
    end
  endtask

  task automatic send_block(input int npilot, input int nbytes, input bit push_exp, input bit glitchy);
    for (int i = 0; i < npilot; i++) begin
      if (glitchy) half_glitch(PIL);
      else half(PIL);
    end
    half(SY1);
    half(SY2);
    for (int b = 0; b < nbytes; b++) begin
      if (push_exp) exp_byte_q.push_back({b == 0, tx_bytes[b]});
      send_byte(tx_bytes[b]);
    end
  endtask

  // Close the last half-pulse, then stay silent past the timeout.
  task automatic finish_block();
    tape_lvl = ~tape_lvl;
    tape_in  = tape_lvl;
    idle(TMO + 40);
  endtask

  always @(negedge clk14) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) begin
        logic [31:0] e;
        if (exp_byte_q.size() != 0) e = 32'(exp_byte_q.pop_front());
        else e = 32'hFFFF_FFFF;
        $display("byte 0x%02h first=%0d", byte_data, byte_first);
        check("byte", 32'({byte_first, byte_data}), e);
      end
      if (block_end) begin
        logic [31:0] e;
        blk_cnt++;
        if (exp_ok_q.size() != 0) e = 32'(exp_ok_q.pop_front());
        else e = 32'hFFFF_FFFF;
        $display("block_end ok=%0d err=%0d", block_ok, err);
        check("block_ok", 32'(block_ok), e);
      end
      if (err) begin
        err_cnt++;
        check("err_with_end", 32'(block_end), 32'd1);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    tape_in    = 1'b0;
    tape_lvl   = 1'b0;
    byte_ready = 1'b0;
    repeat (5) @(posedge clk14);
    #1;
    rst_n = 1'b1;

    check("rst_byte_data", 32'(byte_data), 0);
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_byte_first", 32'(byte_first), 0);
    check("rst_block_active", 32'(block_active), 0);
    check("rst_block_end", 32'(block_end), 0);
    check("rst_overrun", 32'(overrun), 0);
    idle(10);

    // Full block with the consumer always ready.
    byte_ready  = 1'b1;
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hA5; tx_bytes[2] = 8'hA5;
    exp_ok_q.push_back(1'b1);
    send_block(20, 3, 1'b1, 1'b0);
    finish_block();
    check("full_bytes_left", 32'(exp_byte_q.size()), 0);
    check("full_blocks", 32'(blk_cnt), 1);
    check("full_idle", 32'(block_active), 0);

    // Same block, consumer never ready: first byte held, rest overrun.
    byte_ready = 1'b0;
    exp_ok_q.push_back(1'b0);
    send_block(20, 3, 1'b0, 1'b0);
    finish_block();
    check("ovr_blocks", 32'(blk_cnt), 2);
    check("ovr_valid", 32'(byte_valid), 1);
    check("ovr_data", 32'(byte_data), 32'h00);
    check("ovr_first", 32'(byte_first), 1);
    check("ovr_flag", 32'(overrun), 1);
    exp_byte_q.push_back({1'b1, 8'h00});
    byte_ready = 1'b1;
    idle(2);
    check("ovr_drained", 32'(byte_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);

    // Too little pilot: sync must be rejected.
    tx_bytes[0] = 8'h5A;
    send_block(8, 1, 1'b0, 1'b0);
    finish_block();
    check("short_blocks", 32'(blk_cnt), 2);
    check("short_idle", 32'(block_active), 0);

    // Oversized bit pair inside DATA.
    tx_bytes[0] = 8'h3C;
    exp_ok_q.push_back(1'b0);
    send_block(20, 1, 1'b1, 1'b0);
    half(75);
    half(50);
    finish_block();
    check("errp_err_cnt", 32'(err_cnt), 1);
    check("errp_blocks", 32'(blk_cnt), 3);
    check("errp_idle", 32'(block_active), 0);
    check("errp_ovr_clear", 32'(overrun), 0);
    check("errp_bytes_left", 32'(exp_byte_q.size()), 0);

    // Exactly the minimum pilot count, every pilot half glitched.
    tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34; tx_bytes[2] = 8'h26;
    exp_ok_q.push_back(1'b1);
    send_block(P_CNT, 3, 1'b1, 1'b1);
    finish_block();
    check("glitch_blocks", 32'(blk_cnt), 4);
    check("glitch_bytes_left", 32'(exp_byte_q.size()), 0);

    // Reset in the middle of the second byte of a block.
    byte_ready  = 1'b0;
    tx_bytes[0] = 8'hC3;
    send_block(20, 1, 1'b0, 1'b0);
    half(ONE); half(ONE); half(ZERO); half(ZERO);
    check("prerst_active", 32'(block_active), 1);
    check("prerst_valid", 32'(byte_valid), 1);
    check("prerst_data", 32'(byte_data), 32'hC3);
    rst_n = 1'b0;
    @(posedge clk14);
    #1;
    check("midrst_data", 32'(byte_data), 0);
    check("midrst_valid", 32'(byte_valid), 0);
    check("midrst_first", 32'(byte_first), 0);
    check("midrst_active", 32'(block_active), 0);
    check("midrst_end", 32'(block_end), 0);
    check("midrst_ok", 32'(block_ok), 0);
    check("midrst_err", 32'(err), 0);
    rst_n = 1'b1;
    idle(TMO + 40);
    check("midrst_no_end", 32'(blk_cnt), 4);

    byte_ready  = 1'b1;
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hA5; tx_bytes[2] = 8'hA5;
    exp_ok_q.push_back(1'b1);
    send_block(20, 3, 1'b1, 1'b0);
    finish_block();
    check("fresh_blocks", 32'(blk_cnt), 5);
    check("final_byte_q", 32'(exp_byte_q.size()), 0);
    check("final_ok_q", 32'(exp_ok_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
